mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access sequencer (IDLE -> ACCESS -> DONE).
// Issues one registered data-memory request per accepted load/store, waits
// for dm_ack up to TIMEOUT cycles, captures load data and flags bus errors.
// Optional build macro DMEM_MISALIGN_TRAP_EN: traps ops whose address is not
// 8-byte aligned (no request issued, bus_err_M set, straight to DONE).
module mem_access_unit #(
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_M,
  input  logic         memRead_M,
  input  logic         memWrite_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic [N-1:0] readData_M,
  output logic         stall_M,
  output logic         done_M,
  output logic         bus_err_M
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          dm_req_q, dm_req_d;
  logic          dm_we_q, dm_we_d;
  logic [N-1:0]  dm_addr_q, dm_addr_d;
  logic [N-1:0]  dm_wdata_q, dm_wdata_d;
  logic [N-1:0]  read_data_q, read_data_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept_c;
  logic misalign_c;

  // Op acceptance and optional alignment trap decode
  always_comb begin
    accept_c = (state_q == S_IDLE) && start_M && (memRead_M || memWrite_M);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_c = (aluResult_M[2:0] != 3'b000);
`else
    misalign_c = 1'b0;
`endif
  end

  // Next-state and datapath register update
  always_comb begin
    state_d     = state_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    read_data_d = read_data_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          bus_err_d = 1'b0;
          cnt_d     = '0;
          if (misalign_c) begin
            bus_err_d   = 1'b1;
            read_data_d = '0;
            state_d     = S_DONE;
          end else begin
            dm_addr_d  = aluResult_M;
            dm_wdata_d = writeData_M;
            dm_we_d    = memWrite_M;
            dm_req_d   = 1'b1;
            state_d    = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // ack wins over a timeout landing on the same cycle
        if (dm_ack) begin
          if (!dm_we_q) read_data_d = dm_rdata;
          dm_req_d = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dm_req_d    = 1'b0;
          bus_err_d   = 1'b1;
          read_data_d = '0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      read_data_q <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign readData_M = read_data_q;
  assign bus_err_M  = bus_err_q;

  // Pipeline hold is decoded from state so the upstream stage sees it on the acceptance cycle
  assign stall_M = !reset && (accept_c || (state_q == S_ACCESS));
  assign done_M  = !reset && (state_q == S_DONE);

endmodule
